// File: rtl/median_column_feeder_9_if.sv
// Pixel-in / column-out bundle between the raster source, the column feeder and the column sorter.
interface median_column_feeder_9_if #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int CW = $clog2(IMG_WIDTH);

   logic [DATA_WIDTH-1:0] data_i;
   logic                  valid_i;
   logic                  ready_o;
   logic                  done_o;
   logic [DATA_WIDTH-1:0] S1, S2, S3, S4, S5, S6, S7, S8, S9;
   logic [RW-1:0]         row_o;
   logic [CW-1:0]         col_o;
   logic                  frame_done_o;

   modport master (
      output data_i, valid_i,
      input  ready_o, done_o, S1, S2, S3, S4, S5, S6, S7, S8, S9, row_o, col_o, frame_done_o
   );

   modport slave (
      input  data_i, valid_i,
      output ready_o, done_o, S1, S2, S3, S4, S5, S6, S7, S8, S9, row_o, col_o, frame_done_o
   );
endinterface

// File: rtl/median_column_feeder_9.sv
// Buffers 8 lines and emits one zero-padded 9-row column per pixel, registered one cycle after each advance.
// ready_o drops only during the 4-line bottom flush; valid_i gaps in RUN simply pause the pipeline.
module median_column_feeder_9 #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input logic                     clk,
   input logic                     rst,
   median_column_feeder_9_if.slave io
);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int NW = $clog2(IMG_HEIGHT + 4);

   localparam logic [CW-1:0] COL_LAST       = CW'(IMG_WIDTH - 1);
   localparam logic [NW-1:0] ROW_IMG_LAST   = NW'(IMG_HEIGHT - 1);
   localparam logic [NW-1:0] ROW_FLUSH_LAST = NW'(IMG_HEIGHT + 3);
   localparam logic [NW-1:0] ROW_FIRST_EMIT = NW'(4);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         in_col;
   logic [NW-1:0]         in_row;
   logic                  ready;
   logic                  advance;
   logic                  col_wrap;
   logic                  emit;
   logic [DATA_WIDTH-1:0] pix_in;

   logic [DATA_WIDTH-1:0] line_mem [8][IMG_WIDTH];
   logic [DATA_WIDTH-1:0] line_rd  [8];
   logic [DATA_WIDTH-1:0] s_nxt    [9];
   logic [DATA_WIDTH-1:0] s_q      [9];
   logic                  done_q;
   logic                  frame_done_q;
   logic [RW-1:0]         row_q;
   logic [CW-1:0]         col_q;

   always_comb begin
      state_d  = state_q;
      ready    = 1'b0;
      advance  = 1'b0;
      col_wrap = (in_col == COL_LAST);
      case (state_q)
         RUN: begin
            ready   = 1'b1;
            advance = io.valid_i;
            if (advance && col_wrap && (in_row == ROW_IMG_LAST))
               state_d = FLUSH;
         end
         FLUSH: begin
            advance = 1'b1;
            if (col_wrap && (in_row == ROW_FLUSH_LAST))
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_col <= '0;
         in_row <= '0;
      end else if (advance) begin
         if (col_wrap) begin
            in_col <= '0;
            in_row <= (in_row == ROW_FLUSH_LAST) ? '0 : in_row + 1'b1;
         end else begin
            in_col <= in_col + 1'b1;
         end
      end
   end

   assign pix_in = (state_q == FLUSH) ? '0 : io.data_i;
   assign emit   = advance && (in_row >= ROW_FIRST_EMIT);

   // Line j holds input row in_row-1-j at this column; the shift pushes each line one row older.
   always_ff @(posedge clk) begin
      if (advance) begin
         line_mem[0][in_col] <= pix_in;
         for (int j = 1; j < 8; j++)
            line_mem[j][in_col] <= line_mem[j-1][in_col];
      end
   end

   always_comb begin
      for (int j = 0; j < 8; j++)
         line_rd[j] = line_mem[j][in_col];
   end

   // Sample k sits at image row in_row+k-8; rows outside the frame are padded with 0, which also hides stale RAM.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         s_nxt[k] = '0;
         if ((int'(in_row) + k >= 8) && (int'(in_row) + k <= IMG_HEIGHT + 7))
            s_nxt[k] = line_rd[7-k];
      end
      s_nxt[8] = '0;
      if (int'(in_row) <= IMG_HEIGHT - 1)
         s_nxt[8] = pix_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q       <= 1'b0;
         frame_done_q <= 1'b0;
         row_q        <= '0;
         col_q        <= '0;
         for (int k = 0; k < 9; k++) s_q[k] <= '0;
      end else begin
         done_q       <= emit;
         frame_done_q <= advance && col_wrap && (in_row == ROW_FLUSH_LAST);
         if (emit) begin
            row_q <= RW'(in_row - ROW_FIRST_EMIT);
            col_q <= in_col;
            for (int k = 0; k < 9; k++) s_q[k] <= s_nxt[k];
         end
      end
   end

   assign io.ready_o      = ready;
   assign io.done_o       = done_q;
   assign io.frame_done_o = frame_done_q;
   assign io.row_o        = row_q;
   assign io.col_o        = col_q;
   assign io.S1           = s_q[0];
   assign io.S2           = s_q[1];
   assign io.S3           = s_q[2];
   assign io.S4           = s_q[3];
   assign io.S5           = s_q[4];
   assign io.S6           = s_q[5];
   assign io.S7           = s_q[6];
   assign io.S8           = s_q[7];
   assign io.S9           = s_q[8];
endmodule

// File: tb/tb_median_column_feeder_9.sv
// Scoreboard bench: a 4x6 instance for reset/fill/gap/flush/back-to-back, and a 7x9 instance with random valid gaps.
module tb_median_column_feeder_9;
   localparam int W  = 4;
   localparam int H  = 6;
   localparam int W2 = 7;
   localparam int H2 = 9;

   typedef struct {
      int         r;
      int         c;
      logic [71:0] s;
      bit         fd;
   } exp_t;

   typedef struct {
      int         f;
      int         r;
      int         c;
      logic [71:0] s;
   } spot_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   exp_t        q[$];
   logic [71:0] cap [2][H][W];
   int          fcnt [2];
   int          fidx, fdcount, flush_len, last_fd_cyc;
   int          ber, bec, bcnt, bfd;
   spot_t       spots [5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   median_column_feeder_9_if #(.DATA_WIDTH(8), .IMG_WIDTH(W),  .IMG_HEIGHT(H))  ifa ();
   median_column_feeder_9_if #(.DATA_WIDTH(8), .IMG_WIDTH(W2), .IMG_HEIGHT(H2)) ifb ();

   median_column_feeder_9 #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut_a (
      .clk (clk),
      .rst (rst),
      .io  (ifa.slave)
   );

   median_column_feeder_9 #(.DATA_WIDTH(8), .IMG_WIDTH(W2), .IMG_HEIGHT(H2)) dut_b (
      .clk (clk),
      .rst (rst),
      .io  (ifb.slave)
   );

   function automatic logic [7:0] pix(input int base, input int r, input int c);
      return 8'(base + r * 16 + c);
   endfunction

   // {S1..S9} for centre (cr, c): S_k is image row cr+k-5, zero outside the frame.
   function automatic logic [71:0] col_exp(input int base, input int cr, input int c, input int hh);
      logic [71:0] s;
      s = '0;
      for (int k = 1; k <= 9; k++) begin
         int rr;
         rr = cr + k - 5;
         if (rr >= 0 && rr < hh) s[(9-k)*8 +: 8] = pix(base, rr, c);
      end
      return s;
   endfunction

   task automatic check(input bit ok, input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, got, exp);
      end
   endtask

   task automatic push_exp(input int base, input int r, input int c);
      exp_t e;
      if (r >= 4) begin
         e.r = r - 4; e.c = c; e.s = col_exp(base, r - 4, c, H); e.fd = 1'b0;
         q.push_back(e);
      end
      if (r == H - 1 && c == W - 1) begin
         for (int cr = H - 4; cr < H; cr++)
            for (int cc = 0; cc < W; cc++) begin
               e.r = cr; e.c = cc; e.s = col_exp(base, cr, cc, H);
               e.fd = (cr == H - 1 && cc == W - 1);
               q.push_back(e);
            end
      end
   endtask

   task automatic send_a(input int base, input int r, input int c, input bit gap, output int acc_cyc);
      bit acc;
      int n;
      if (gap) begin
         ifa.valid_i = 1'b0;
         @(posedge clk); #1;
      end
      ifa.valid_i = 1'b1;
      ifa.data_i  = pix(base, r, c);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = ifa.ready_o;
         @(posedge clk); #1;
         n++;
      end
      if (!acc) check(1'b0, "accept_timeout_a", 128'(n), 128'(200));
      acc_cyc = cyc;
      push_exp(base, r, c);
   endtask

   task automatic send_frame_a(input int base, input int gap_row, input bit b2b);
      int ac;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            send_a(base, r, c, (r == gap_row) && (c % 2 == 1), ac);
            if (b2b && r == 0 && c == 0)
               check(ac == last_fd_cyc + 1, "b2b_first_accept_cycle", 128'(ac), 128'(last_fd_cyc + 1));
         end
   endtask

   task automatic mon_a();
      exp_t        e;
      logic [71:0] got;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            fidx = 0; fdcount = 0; flush_len = 0;
            fcnt[0] = 0; fcnt[1] = 0;
         end else begin
            if (!ifa.ready_o) flush_len++;
            else if (flush_len != 0) begin
               check(flush_len == 4 * W, "flush_ready_low_cycles", 128'(flush_len), 128'(4 * W));
               flush_len = 0;
            end
            got = {ifa.S1, ifa.S2, ifa.S3, ifa.S4, ifa.S5, ifa.S6, ifa.S7, ifa.S8, ifa.S9};
            if (ifa.done_o) begin
               if (q.size() == 0) begin
                  check(1'b0, "unexpected_done", {ifa.row_o, ifa.col_o, got}, 128'(0));
               end else begin
                  e = q.pop_front();
                  check(int'(ifa.row_o) == e.r && int'(ifa.col_o) == e.c && got == e.s && ifa.frame_done_o == e.fd,
                        "column", {8'(ifa.row_o), 8'(ifa.col_o), got, 8'(ifa.frame_done_o)},
                        {8'(e.r), 8'(e.c), e.s, 8'(e.fd)});
               end
               if (fidx < 2) begin
                  cap[fidx][ifa.row_o][ifa.col_o] = got;
                  fcnt[fidx]++;
               end
               if (ifa.frame_done_o) begin
                  fdcount++;
                  fidx++;
                  last_fd_cyc = cyc;
               end
            end else if (ifa.frame_done_o) begin
               check(1'b0, "frame_done_without_done", 128'(1), 128'(0));
            end
         end
      end
   endtask

   task automatic mon_b();
      forever begin
         @(negedge clk);
         if (!rst && ifb.done_o) begin
            check(int'(ifb.row_o) == ber && int'(ifb.col_o) == bec, "b_raster_order",
                  {8'(ifb.row_o), 8'(ifb.col_o)}, {8'(ber), 8'(bec)});
            check(ifb.S5 == pix(0, ber, bec), "b_centre_pixel", 128'(ifb.S5), 128'(pix(0, ber, bec)));
            if (ifb.frame_done_o) begin
               bfd++;
               check(ber == H2 - 1 && bec == W2 - 1, "b_frame_done_position",
                     {8'(ber), 8'(bec)}, {8'(H2 - 1), 8'(W2 - 1)});
            end
            bcnt++;
            if (bec == W2 - 1) begin
               bec = 0;
               ber = (ber == H2 - 1) ? 0 : ber + 1;
            end else begin
               bec++;
            end
         end
      end
   endtask

   initial begin
      int ac, n;
      bit acc;

      spots[0] = '{0, 0, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40}};
      spots[1] = '{0, 1, 2, {8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h22, 8'h32, 8'h42, 8'h52}};
      spots[2] = '{0, 5, 2, {8'h12, 8'h22, 8'h32, 8'h42, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00}};
      spots[3] = '{0, 5, 3, {8'h13, 8'h23, 8'h33, 8'h43, 8'h53, 8'h00, 8'h00, 8'h00, 8'h00}};
      spots[4] = '{1, 0, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0}};

      ifa.valid_i = 1'b0; ifa.data_i = '0;
      ifb.valid_i = 1'b0; ifb.data_i = '0;
      ber = 0; bec = 0; bcnt = 0; bfd = 0; last_fd_cyc = -10;
      rst = 1'b1;
      fork
         mon_a();
         mon_b();
      join_none
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Partial stale frame, then a mid-stream reset.
      for (int i = 0; i < 19; i++) begin
         send_a(8'h40, i / W, i % W, 1'b0, ac);
      end
      ifa.valid_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      ifa.valid_i = 1'b1;
      ifa.data_i  = 8'hEE;
      @(posedge clk); #1;
      rst = 1'b0;
      ifa.valid_i = 1'b0;
      @(negedge clk);
      check(ifa.ready_o == 1'b1, "reset_ready", 128'(ifa.ready_o), 128'(1));
      check(ifa.done_o == 1'b0 && ifa.frame_done_o == 1'b0, "reset_done",
            {ifa.done_o, ifa.frame_done_o}, 128'(0));
      check({ifa.S1, ifa.S2, ifa.S3, ifa.S4, ifa.S5, ifa.S6, ifa.S7, ifa.S8, ifa.S9} == '0, "reset_samples",
            {ifa.S1, ifa.S2, ifa.S3, ifa.S4, ifa.S5, ifa.S6, ifa.S7, ifa.S8, ifa.S9}, 128'(0));
      check(ifa.row_o == '0 && ifa.col_o == '0, "reset_row_col", {ifa.row_o, ifa.col_o}, 128'(0));
      @(posedge clk); #1;

      // Fresh frame with valid gaps in row 5, then a back-to-back second frame.
      send_frame_a(0, 5, 1'b0);
      send_frame_a(8'h80, -1, 1'b1);
      ifa.valid_i = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(q.size() == 0, "a_drain", 128'(q.size()), 128'(0));
      repeat (3) @(posedge clk);
      #1;
      check(fcnt[0] == W * H, "frame0_done_count", 128'(fcnt[0]), 128'(W * H));
      check(fcnt[1] == W * H, "frame1_done_count", 128'(fcnt[1]), 128'(W * H));
      check(fdcount == 2, "frame_done_count", 128'(fdcount), 128'(2));
      for (int i = 0; i < 5; i++)
         check(cap[spots[i].f][spots[i].r][spots[i].c] == spots[i].s, "spot_column",
               cap[spots[i].f][spots[i].r][spots[i].c], spots[i].s);

      // 7x9 frame with random valid gaps.
      for (int r = 0; r < H2; r++)
         for (int c = 0; c < W2; c++) begin
            while ($urandom_range(0, 2) == 0) begin
               ifb.valid_i = 1'b0;
               @(posedge clk); #1;
            end
            ifb.valid_i = 1'b1;
            ifb.data_i  = pix(0, r, c);
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 200) begin
               @(negedge clk);
               acc = ifb.ready_o;
               @(posedge clk); #1;
               n++;
            end
            if (!acc) check(1'b0, "accept_timeout_b", 128'(n), 128'(200));
         end
      ifb.valid_i = 1'b0;
      n = 0;
      while (bcnt < W2 * H2 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check(bcnt == W2 * H2, "b_done_count", 128'(bcnt), 128'(W2 * H2));
      check(bfd == 1, "b_frame_done_count", 128'(bfd), 128'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/median_column_feeder_9.md
Name: median_column_feeder_9

Overview:
- Raster-order pixel front end for the 9x9 median filter. Buffers 8 image lines and emits, for every image pixel, the 9 vertically aligned samples of its 9-row column with a one-cycle valid strobe (done_o). The output drives the done_i/S1..S9 input of the 9-input column sorter.
- Zero-pads the top and bottom image borders.
- Runs an internal bottom-border flush, so exactly W*H columns are emitted per frame.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per line W. Legal range is 2 or more.
- IMG_HEIGHT, 480, lines per frame H. Legal range is 5 or more.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Synchronous, active-high.
- data_i  input  DATA_WIDTH  input pixel, raster order.
- valid_i  input  1  data_i is valid this cycle.
- ready_o  output  1  block accepts a pixel this cycle. A pixel is accepted when valid_i and ready_o are both high.
- done_o  output  1  S1..S9, row_o and col_o are valid this cycle.
- S1..S9  output  DATA_WIDTH each  column samples, top (S1) to bottom (S9). S5 is the centre pixel.
- row_o  output  clog2(IMG_HEIGHT)  centre row of the emitted column.
- col_o  output  clog2(IMG_WIDTH)  centre column of the emitted column.
- frame_done_o  output  1  one-cycle pulse in the same cycle as the last column of the frame.

Behaviour:
- Storage is 8 line RAMs, each W deep, arranged as a shift chain. On every advance at column c:
  - line k is read at address c;
  - line 0 is written with the new pixel (or 0 during flush);
  - line k is written with the old contents of line k-1.
- Counters:
  - in_col counts 0..W-1 and wraps.
  - in_row counts 0..H+3 and increments on in_col wrap.
  - Rows H..H+3 are flush rows.
- States:
  - RUN: ready_o=1. Advances only on accepted pixels. Moves to FLUSH when pixel (H-1, W-1) is accepted.
  - FLUSH: ready_o=0. Advances every cycle with the input treated as 0. Runs 4*W cycles, then returns to RUN with counters at 0, ready for the next frame. valid_i is ignored in FLUSH.
- Emission:
  - An advance at input row r, column c emits centre cr=r-4, col c, but only when cr>=0. Input rows 0..3 emit nothing.
  - S_k holds image row cr+k-5. S_k is forced to 0 when that row is below 0 or above H-1.
  - This masking is by counter only. RAM contents are never cleared.
- Latency: done_o and the samples are registered, one cycle after the advance. Pipeline stalls (no advance) hold done_o low. Outputs other than done_o and frame_done_o hold their last values.
- frame_done_o asserts with done_o for centre (H-1, W-1), i.e. the last flush cycle's output.
- Output count: exactly W*H done_o pulses per frame, with row_o/col_o in raster order 0..H-1, 0..W-1.
- Reset values: ready_o=1 after reset. done_o, frame_done_o, S1..S9, row_o and col_o are all 0. State is RUN and counters are 0.
- Reset mid-frame (including mid-flush): the state above applies on the next cycle. The next accepted pixel is (0,0) of a new frame. Stale RAM data never reaches S1..S9 before it is overwritten, because of the row mask.
- Back-to-back frames: the first pixel of frame n+1 is accepted on the cycle after FLUSH ends. No extra idle cycle.
- valid_i gaps in RUN pause all counters and produce no emission.

Test Plan:
All scenarios use W=4, H=6 and pixel value row*16+col, unless stated.
1. Reset: assert rst mid-stream -> next cycle ready_o=1, done_o=0, S1..S9=0. The next 24 pixels behave as a fresh frame.
2. Fill: stream rows 0..3 -> no done_o. Accept pixel (4,0) -> next cycle done_o=1, row_o=0, col_o=0, S1..S4=0, S5..S9=00,10,20,30,40.
3. Interior with valid_i gaps: toggle valid_i 1-0-1 through row 5 -> centre (1,2) shows S1..S3=0, S4..S9=02,12,22,32,42,52. No done_o in gap cycles.
4. Flush: after pixel (5,3) -> ready_o=0 for exactly 16 cycles, with 16 done_o pulses. Centre (5,2) shows S1..S5=12,22,32,42,52 and S6..S9=0. frame_done_o pulses with centre (5,3).
5. Back-to-back frames: frame 2 pixels use value +0x80 -> exactly 24 done_o pulses per frame. The first frame-2 output is centre (0,0) with S5=80, S6..S9=90,A0,B0,C0, and S1..S4=0 (no frame-1 leakage).
6. Count check: random valid_i at W=7, H=9 -> 63 done_o pulses, raster-ordered row_o/col_o, and a single frame_done_o.
